// File: rtl/interrupt_collector.sv
// rtl/interrupt_collector.sv - round-robin interrupt source arbiter feeding the TLX interrupt stage
module interrupt_collector #(
  parameter int NSRC = 4,
  parameter int CTXW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_req,
  input  logic [NSRC*64-1:0]   src_obj,
  input  logic [NSRC*CTXW-1:0] src_ctx,
  output logic [NSRC-1:0]      src_ack,
  output logic                 interrupt,
  output logic [63:0]          interrupt_src,
  output logic [8:0]           interrupt_ctx,
  input  logic                 interrupt_ack,
  output logic [31:0]          intr_count,
  output logic                 busy
);

  localparam int IW = $clog2(NSRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic [IW:0]     cand;
  logic            any_req;
  logic [63:0]     pick_obj;
  logic [CTXW-1:0] pick_ctx;

  // Round-robin pick: scan downward so the candidate closest to rr_ptr wins last.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NSRC)) begin
        cand = cand - (IW+1)'(NSRC);
      end
      if (src_req[cand[IW-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[IW-1:0];
      end
    end
  end

  assign pick_obj = src_obj[64*int'(pick) +: 64];
  assign pick_ctx = src_ctx[CTXW*int'(pick) +: CTXW];
  assign next_ptr = (pick == IW'(NSRC - 1)) ? '0 : pick + 1'b1;

  // Grant/issue/release handshake with the TLX stage; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      interrupt     <= 1'b0;
      interrupt_src <= '0;
      interrupt_ctx <= '0;
      src_ack       <= '0;
      intr_count    <= '0;
      busy          <= 1'b0;
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= pick;
            rr_ptr        <= next_ptr;
            interrupt_src <= pick_obj;
            interrupt_ctx <= 9'(pick_ctx);
            interrupt     <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (interrupt_ack) begin
            interrupt      <= 1'b0;
            src_ack[grant] <= 1'b1;
            if (intr_count != 32'hFFFF_FFFF) begin
              intr_count <= intr_count + 32'd1;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Hold off until the TLX stage drops its ack so it never sees a new request early.
          if (!interrupt_ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          interrupt <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_collector.sv
// tb/tb_interrupt_collector.sv - self-checking bench for interrupt_collector
module tb_interrupt_collector;

  localparam int NSRC = 4;
  localparam int CTXW = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSRC-1:0]      src_req;
  logic [NSRC*64-1:0]   src_obj;
  logic [NSRC*CTXW-1:0] src_ctx;
  logic [NSRC-1:0]      src_ack;
  logic                 interrupt;
  logic [63:0]          interrupt_src;
  logic [8:0]           interrupt_ctx;
  logic                 interrupt_ack;
  logic [31:0]          intr_count;
  logic                 busy;

  interrupt_collector #(.NSRC(NSRC), .CTXW(CTXW)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_obj(src_obj), .src_ctx(src_ctx),
    .src_ack(src_ack), .interrupt(interrupt), .interrupt_src(interrupt_src),
    .interrupt_ctx(interrupt_ctx), .interrupt_ack(interrupt_ack),
    .intr_count(intr_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_int, m_found;
  logic [63:0] m_src;
  logic [8:0]  m_ctx;
  logic [3:0]  m_ack;
  logic [31:0] m_cnt;
  int          m_ptr, m_g, m_idx;
  int          m_grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_int = 0; m_src = '0; m_ctx = '0; m_ack = '0; m_cnt = '0;
      m_ptr = 0; m_g = 0;
    end else begin
      m_ack = '0;
      if (!m_busy) begin
        m_found = 0;
        for (int k = 0; k < NSRC; k++) begin
          m_idx = (m_ptr + k) % NSRC;
          if (!m_found && src_req[m_idx]) begin
            m_found = 1;
            m_g = m_idx;
          end
        end
        if (m_found) begin
          m_src  = src_obj[m_g*64 +: 64];
          m_ctx  = 9'(src_ctx[m_g*CTXW +: CTXW]);
          m_int  = 1;
          m_busy = 1;
          m_ptr  = (m_g + 1) % NSRC;
          m_grants.push_back(m_g);
        end
      end else if (m_int) begin
        if (interrupt_ack) begin
          m_int = 0;
          m_ack = 4'b0001 << m_g;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
      end else if (!interrupt_ack) begin
        m_busy = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("interrupt", interrupt, m_int);
    chk("interrupt_src", interrupt_src, m_src);
    chk("interrupt_ctx", interrupt_ctx, m_ctx);
    chk("src_ack", src_ack, m_ack);
    chk("intr_count", intr_count, m_cnt);
    chk("busy", busy, m_busy);
  end

  // ---------------- monitor ----------------
  int         dut_acks[$];
  int         ack_pulses, hi_run, last_hi, lo_run, min_gap;
  bit         had_pulse;
  logic [3:0] last_ack_vec;

  always @(negedge clk) begin
    if (src_ack != 0) begin
      ack_pulses++;
      last_ack_vec = src_ack;
      for (int i = 0; i < NSRC; i++) if (src_ack[i]) dut_acks.push_back(i);
    end
    if (interrupt) begin
      if (hi_run == 0 && had_pulse && lo_run < min_gap) min_gap = lo_run;
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run > 0) begin
        last_hi = hi_run;
        hi_run = 0;
        had_pulse = 1;
      end
      lo_run++;
    end
  end

  task automatic clear_log();
    dut_acks.delete(); m_grants.delete();
    ack_pulses = 0; hi_run = 0; last_hi = 0; lo_run = 0; had_pulse = 0;
    min_gap = 1000; last_ack_vec = '0;
  endtask

  // ---------------- TLX stage and source agents ----------------
  bit tlx_en;
  int tlx_delay, tlx_hold, hi_cnt, hold_cnt;
  logic [3:0] rearm, rearm_pend;

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_cnt = 0; hold_cnt = 0;
    end else if (tlx_en) begin
      if (interrupt_ack) begin
        hold_cnt++;
        if (hold_cnt >= tlx_hold) begin interrupt_ack = 0; hold_cnt = 0; end
      end else if (interrupt) begin
        hi_cnt++;
        if (hi_cnt >= tlx_delay) begin interrupt_ack = 1; hi_cnt = 0; end
      end else begin
        hi_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        if (rearm_pend[i]) begin src_req[i] = 1'b1; rearm_pend[i] = 1'b0; end
        if (src_ack[i]) begin
          src_req[i] = 1'b0;
          if (rearm[i]) rearm_pend[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    tlx_en = 0; interrupt_ack = 0; src_req = '0; rearm = '0; rearm_pend = '0;
    @(posedge clk); #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    clear_log();
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int c = 0;
    while (ack_pulses < n && c < budget) begin @(posedge clk); #2; c++; end
    chk(name, 64'(ack_pulses >= n), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((busy || interrupt_ack) && c < budget) begin @(posedge clk); #2; c++; end
    chk("reach_idle", busy, 1'b0);
  endtask

  task automatic wait_int(input int budget);
    int c = 0;
    while (!interrupt && c < budget) begin @(posedge clk); #2; c++; end
    chk("interrupt_rises", interrupt, 1'b1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_interrupt"}, interrupt, 1'b0);
    chk({tag, "_src"}, interrupt_src, 64'd0);
    chk({tag, "_ctx"}, interrupt_ctx, 9'd0);
    chk({tag, "_src_ack"}, src_ack, 4'd0);
    chk({tag, "_count"}, intr_count, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int saved_pulses;
    int exp_order4[4];
    int exp_fair[4];
    rst_n = 0; src_req = '0; src_obj = '0; src_ctx = '0; interrupt_ack = 0;
    tlx_en = 0; tlx_delay = 2; tlx_hold = 1; rearm = '0; rearm_pend = '0;
    clear_log();

    // Reset state
    repeat (3) @(posedge clk);
    #2 chk_zero_outputs("reset");
    rst_n = 1;
    clear_log();

    // Single request from source 2, TLX acks after 6 cycles for 3 cycles
    src_obj[2*64 +: 64] = 64'hDEAD_BEEF_0000_0040;
    src_ctx[2*CTXW +: CTXW] = 9'h05;
    tlx_delay = 6; tlx_hold = 3; tlx_en = 1;
    src_req = 4'b0100;
    wait_acks(1, 100, "single_ack_timeout");
    wait_idle(50);
    chk("single_ack_count", 64'(ack_pulses), 64'd1);
    chk("single_ack_vec", last_ack_vec, 4'b0100);
    chk("single_high_cycles", 64'(last_hi), 64'd6);
    chk("single_src", interrupt_src, 64'hDEAD_BEEF_0000_0040);
    chk("single_ctx", interrupt_ctx, 9'h005);
    chk("single_count", intr_count, 32'd1);
    chk("single_model_count", m_cnt, 32'd1);
    chk("single_model_grant", 64'(m_grants.size() == 1 && m_grants[0] == 2), 64'd1);

    // All four at once after reset: order 0,1,2,3 from a fresh pointer
    do_reset();
    for (int i = 0; i < NSRC; i++) begin
      src_obj[i*64 +: 64] = 64'h1000 + 64'(i);
      src_ctx[i*CTXW +: CTXW] = 9'(i + 1);
    end
    tlx_delay = 2; tlx_hold = 1; tlx_en = 1;
    src_req = 4'b1111;
    wait_acks(4, 200, "all4_timeout");
    wait_idle(50);
    exp_order4 = '{0, 1, 2, 3};
    chk("all4_n_acks", 64'(dut_acks.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_acks.size()) chk("all4_order", 64'(dut_acks[i]), 64'(exp_order4[i]));
      if (i < m_grants.size()) chk("all4_model_order", 64'(m_grants[i]), 64'(exp_order4[i]));
    end
    chk("all4_count", intr_count, 32'd4);
    chk("all4_min_gap", 64'(min_gap >= 2), 64'd1);
    chk("all4_last_src", interrupt_src, 64'h1003);
    chk("all4_last_ctx", interrupt_ctx, 9'h004);

    // Fairness: source 0 re-requests after each ack, source 3 keeps requesting
    do_reset();
    tlx_delay = 2; tlx_hold = 1; tlx_en = 1;
    rearm = 4'b1001;
    src_req = 4'b1001;
    wait_acks(4, 300, "fair_timeout");
    rearm = '0; rearm_pend = '0; src_req = '0;
    wait_idle(50);
    exp_fair = '{0, 3, 0, 3};
    chk("fair_n_acks", 64'(dut_acks.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_acks.size()) chk("fair_order", 64'(dut_acks[i]), 64'(exp_fair[i]));
      if (i < m_grants.size()) chk("fair_model_order", 64'(m_grants[i]), 64'(exp_fair[i]));
    end

    // TLX ack while idle must be ignored
    tlx_en = 0;
    saved_pulses = ack_pulses;
    interrupt_ack = 1;
    repeat (3) begin
      @(posedge clk); #2;
      chk("idle_ack_busy", busy, 1'b0);
      chk("idle_ack_int", interrupt, 1'b0);
    end
    interrupt_ack = 0;
    @(posedge clk); #2;
    chk("idle_ack_no_pulse", 64'(ack_pulses), 64'(saved_pulses));
    chk("idle_ack_count", intr_count, 32'd4);

    // Hold during backoff: ack withheld 500 cycles while obj0 changes
    do_reset();
    src_obj[63:0] = 64'hA5A5_0000_1111_2222;
    tlx_delay = 500; tlx_hold = 1; tlx_en = 1;
    src_req = 4'b0001;
    wait_int(20);
    for (int j = 0; j < 20; j++) begin
      repeat (10) @(posedge clk);
      #2 src_obj[63:0] = {$urandom, $urandom};
      chk("backoff_held_src", interrupt_src, 64'hA5A5_0000_1111_2222);
      chk("backoff_held_int", interrupt, 1'b1);
    end
    wait_acks(1, 1000, "backoff_timeout");
    wait_idle(50);
    chk("backoff_high_cycles", 64'(last_hi), 64'd500);
    chk("backoff_src", interrupt_src, 64'hA5A5_0000_1111_2222);

    // Reset in the middle of ISSUE, then a pending request from source 3
    tlx_delay = 50; tlx_hold = 1; tlx_en = 1;
    src_req = 4'b0010;
    wait_int(20);
    repeat (3) @(posedge clk);
    #2 src_req = 4'b1000;
    @(posedge clk);
    #2 rst_n = 0;
    tlx_en = 0; interrupt_ack = 0;
    #1 chk_zero_outputs("midreset");
    @(posedge clk); #2;
    chk_zero_outputs("midreset_edge");
    rst_n = 1;
    clear_log();
    tlx_delay = 3; tlx_hold = 1; tlx_en = 1;
    wait_acks(1, 100, "midreset_timeout");
    wait_idle(50);
    chk("midreset_grant", 64'(dut_acks.size() == 1 && dut_acks[0] == 3), 64'd1);
    chk("midreset_ack_vec", last_ack_vec, 4'b1000);
    chk("midreset_count", intr_count, 32'd1);

    // Saturation of the completion counter
    clear_log();
    @(posedge clk);
    #2 force dut.intr_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.intr_count;
    chk("sat_preset", intr_count, 32'hFFFF_FFFE);
    tlx_delay = 2; tlx_hold = 1;
    src_req = 4'b0111;
    wait_acks(3, 200, "sat_timeout");
    wait_idle(50);
    chk("sat_count", intr_count, 32'hFFFF_FFFF);
    chk("sat_model_count", m_cnt, 32'hFFFF_FFFF);
    chk("sat_n_acks", 64'(ack_pulses), 64'd3);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
